// File: rtl/rx_ipv4.sv
// IPv4 receive stage: parses and validates the header as it streams in, then forwards
// the payload one cycle later with last/done/err framing pulses.
module rx_ipv4 (
    input  logic        RX_CLK,
    input  logic        rst,
    input  logic [31:0] ip_addr,
    input  logic        rx_payload_ipv4,
    input  logic [7:0]  rx_payload,
    output logic [31:0] rx_ip_src,
    output logic [7:0]  rx_ip_protocol,
    output logic        rx_ip_payload_valid,
    output logic [7:0]  rx_ip_payload,
    output logic        rx_ip_last,
    output logic        rx_ip_done,
    output logic        rx_ip_err
);
    typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, DISCARD, DONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] sum_q, sum_d;
    logic [7:0]  hi_q, hi_d;
    logic [3:0]  ver_q, ver_d;
    logic [3:0]  ihl_q, ihl_d;
    logic [15:0] tot_q, tot_d;
    logic [13:0] frag_q, frag_d;
    logic [7:0]  proto_q, proto_d;
    logic [31:0] src_q, src_d;
    logic [31:0] dst_q, dst_d;
    logic [15:0] plen_q, plen_d;
    logic [31:0] osrc_q, osrc_d;
    logic [7:0]  oproto_q, oproto_d;
    logic [7:0]  pd_q, pd_d;
    logic        pv_q, pv_d;
    logic        last_q, last_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic [16:0] add;
    logic [15:0] hlen;
    logic [15:0] hlast;
    logic        accept;

    assign add   = {1'b0, sum_q} + {1'b0, hi_q, rx_payload};
    assign hlen  = {10'd0, ihl_q, 2'b00};
    // A short IHL is rejected anyway; still wait for the fixed 20-byte header so dst is seen.
    assign hlast = (ihl_q < 4'd5) ? 16'd19 : hlen - 16'd1;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        hi_d     = hi_q;
        ver_d    = ver_q;
        ihl_d    = ihl_q;
        tot_d    = tot_q;
        frag_d   = frag_q;
        proto_d  = proto_q;
        src_d    = src_q;
        dst_d    = dst_q;
        plen_d   = plen_q;
        osrc_d   = osrc_q;
        oproto_d = oproto_q;
        pd_d     = pd_q;
        pv_d     = 1'b0;
        last_d   = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        accept   = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_payload_ipv4) begin
                    state_d = HEADER;
                    cnt_d   = 16'd1;
                    sum_d   = 16'd0;
                    hi_d    = rx_payload;
                    ver_d   = rx_payload[7:4];
                    ihl_d   = rx_payload[3:0];
                end
            end
            HEADER: begin
                if (!rx_payload_ipv4) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                    // Odd bytes close a big-endian pair; fold the carry straight back in.
                    if (cnt_q[0]) sum_d = add[15:0] + {15'd0, add[16]};
                    else          hi_d  = rx_payload;
                    case (cnt_q)
                        16'd2:  tot_d  = {rx_payload, tot_q[7:0]};
                        16'd3:  tot_d  = {tot_q[15:8], rx_payload};
                        16'd6:  frag_d = {rx_payload[5:0], frag_q[7:0]};
                        16'd7:  frag_d = {frag_q[13:8], rx_payload};
                        16'd9:  proto_d = rx_payload;
                        16'd12, 16'd13, 16'd14, 16'd15: src_d = {src_q[23:0], rx_payload};
                        16'd16, 16'd17, 16'd18, 16'd19: dst_d = {dst_q[23:0], rx_payload};
                        default: ;
                    endcase
                    if (cnt_q == hlast) begin
                        accept = (ver_q == 4'd4) && (ihl_q >= 4'd5) && (sum_d == 16'hFFFF) &&
                                 !frag_d[13] && (frag_d[12:0] == 13'd0) && (tot_d >= hlen) &&
                                 ((dst_d == ip_addr) || (dst_d == 32'hFFFF_FFFF));
                        if (accept) begin
                            osrc_d   = src_d;
                            oproto_d = proto_d;
                            plen_d   = tot_d - hlen;
                            cnt_d    = 16'd0;
                            if (tot_d == hlen) begin
                                state_d = DONE;
                                done_d  = 1'b1;
                            end else begin
                                state_d = PAYLOAD;
                            end
                        end else begin
                            err_d   = 1'b1;
                            state_d = DISCARD;
                        end
                    end
                end
            end
            PAYLOAD: begin
                if (!rx_payload_ipv4) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    pv_d  = 1'b1;
                    pd_d  = rx_payload;
                    cnt_d = cnt_q + 16'd1;
                    if (cnt_q + 16'd1 == plen_q) begin
                        last_d  = 1'b1;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = rx_payload_ipv4 ? DISCARD : IDLE;
            DISCARD: if (!rx_payload_ipv4) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge RX_CLK or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sum_q    <= '0;
            hi_q     <= '0;
            ver_q    <= '0;
            ihl_q    <= '0;
            tot_q    <= '0;
            frag_q   <= '0;
            proto_q  <= '0;
            src_q    <= '0;
            dst_q    <= '0;
            plen_q   <= '0;
            osrc_q   <= '0;
            oproto_q <= '0;
            pd_q     <= '0;
            pv_q     <= 1'b0;
            last_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            hi_q     <= hi_d;
            ver_q    <= ver_d;
            ihl_q    <= ihl_d;
            tot_q    <= tot_d;
            frag_q   <= frag_d;
            proto_q  <= proto_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            plen_q   <= plen_d;
            osrc_q   <= osrc_d;
            oproto_q <= oproto_d;
            pd_q     <= pd_d;
            pv_q     <= pv_d;
            last_q   <= last_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign rx_ip_src           = osrc_q;
    assign rx_ip_protocol      = oproto_q;
    assign rx_ip_payload_valid = pv_q;
    assign rx_ip_payload       = pd_q;
    assign rx_ip_last          = last_q;
    assign rx_ip_done          = done_q;
    assign rx_ip_err           = err_q;
endmodule

// File: tb/tb_rx_ipv4.sv
// Bench for rx_ipv4: directed and randomized datagrams judged by a byte-level reference model.
module tb_rx_ipv4;
    logic        RX_CLK = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] ip_addr = 32'hC0A8_0001;
    logic        rx_payload_ipv4 = 1'b0;
    logic [7:0]  rx_payload = 8'h00;
    logic [31:0] rx_ip_src;
    logic [7:0]  rx_ip_protocol;
    logic        rx_ip_payload_valid;
    logic [7:0]  rx_ip_payload;
    logic        rx_ip_last;
    logic        rx_ip_done;
    logic        rx_ip_err;

    always #5 RX_CLK = ~RX_CLK;

    rx_ipv4 dut (
        .RX_CLK(RX_CLK), .rst(rst), .ip_addr(ip_addr),
        .rx_payload_ipv4(rx_payload_ipv4), .rx_payload(rx_payload),
        .rx_ip_src(rx_ip_src), .rx_ip_protocol(rx_ip_protocol),
        .rx_ip_payload_valid(rx_ip_payload_valid), .rx_ip_payload(rx_ip_payload),
        .rx_ip_last(rx_ip_last), .rx_ip_done(rx_ip_done), .rx_ip_err(rx_ip_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  frm[$];
    logic [7:0]  obs_b[$];
    int          obs_last[$];
    int          obs_done = 0;
    int          obs_err = 0;
    int          obs_both = 0;
    logic [7:0]  exp_b[$];
    int          exp_done;
    int          exp_err;
    logic [31:0] exp_src = 32'h0;
    logic [7:0]  exp_proto = 8'h0;

    always @(negedge RX_CLK) begin
        if (rst) begin
            if (rx_ip_payload_valid) begin
                obs_b.push_back(rx_ip_payload);
                if (rx_ip_last) obs_last.push_back(obs_b.size() - 1);
            end else if (rx_ip_last) begin
                obs_last.push_back(-1);
            end
            if (rx_ip_done) obs_done++;
            if (rx_ip_err) obs_err++;
            if (rx_ip_done && rx_ip_err) obs_both++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic lit_frame();
        frm = '{8'h45, 8'h00, 8'h00, 8'h1C, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
                8'hB9, 8'h7D, 8'hC0, 8'hA8, 8'h00, 8'h02, 8'hC0, 8'hA8, 8'h00, 8'h01};
        for (int i = 1; i <= 8; i++) frm.push_back(8'(i));
    endtask

    task automatic build(input int ihl, input int plen, input logic [31:0] src,
                         input logic [31:0] dst, input logic [7:0] proto, input logic [15:0] fl,
                         input bit bad, input bit rnd, input int pad);
        int          hl;
        int          tot;
        logic [31:0] s;
        logic [15:0] c;
        hl  = ihl * 4;
        tot = hl + plen;
        frm.delete();
        frm.push_back({4'd4, 4'(ihl)}); frm.push_back(8'h00);
        frm.push_back(tot[15:8]);       frm.push_back(tot[7:0]);
        frm.push_back(8'h12);           frm.push_back(8'h34);
        frm.push_back(fl[15:8]);        frm.push_back(fl[7:0]);
        frm.push_back(8'h40);           frm.push_back(proto);
        frm.push_back(8'h00);           frm.push_back(8'h00);
        for (int i = 3; i >= 0; i--) frm.push_back(src[8*i +: 8]);
        for (int i = 3; i >= 0; i--) frm.push_back(dst[8*i +: 8]);
        while (frm.size() < hl) frm.push_back(8'($urandom));
        s = 0;
        for (int i = 0; i < hl; i += 2) s += {16'h0, frm[i], frm[i+1]};
        while (s > 32'hFFFF) s = {16'h0, s[15:0]} + (s >> 16);
        c = ~s[15:0];
        if (bad) c = c ^ 16'h0001;
        frm[10] = c[15:8];
        frm[11] = c[7:0];
        for (int i = 0; i < plen; i++) frm.push_back(rnd ? 8'($urandom) : 8'(i + 1));
        for (int i = 0; i < pad; i++) frm.push_back(8'($urandom));
    endtask

    // Reference: what the first n bytes of frm should produce.
    task automatic model(input int n);
        int          ihl;
        int          hl;
        int          tot;
        logic [31:0] s;
        logic [31:0] dst;
        bit          ok;
        exp_b.delete();
        exp_done = 0;
        exp_err  = 0;
        if (n == 0) return;
        ihl = int'(frm[0][3:0]);
        hl  = (ihl < 5) ? 20 : ihl * 4;
        if (n < hl) begin exp_err = 1; return; end
        s = 0;
        for (int i = 0; i < hl; i += 2) s += {16'h0, frm[i], frm[i+1]};
        while (s > 32'hFFFF) s = {16'h0, s[15:0]} + (s >> 16);
        tot = int'({frm[2], frm[3]});
        dst = {frm[16], frm[17], frm[18], frm[19]};
        ok = (frm[0][7:4] == 4'd4) && (ihl >= 5) && (s == 32'hFFFF) && !frm[6][5] &&
             ({frm[6][4:0], frm[7]} == 13'd0) && (tot >= hl) &&
             ((dst == ip_addr) || (dst == 32'hFFFF_FFFF));
        if (!ok) begin exp_err = 1; return; end
        exp_src   = {frm[12], frm[13], frm[14], frm[15]};
        exp_proto = frm[9];
        for (int i = hl; i < n && i < tot; i++) exp_b.push_back(frm[i]);
        if (n >= tot) exp_done = 1;
        else          exp_err  = 1;
    endtask

    task automatic clear_obs();
        obs_b.delete();
        obs_last.delete();
        obs_done = 0;
        obs_err  = 0;
        obs_both = 0;
    endtask

    task automatic run(input int n, input string tag);
        int m;
        clear_obs();
        for (int i = 0; i < n; i++) begin
            @(posedge RX_CLK); #1;
            rx_payload_ipv4 = 1'b1;
            rx_payload      = frm[i];
        end
        @(posedge RX_CLK); #1;
        rx_payload_ipv4 = 1'b0;
        rx_payload      = 8'h00;
        repeat (4) @(posedge RX_CLK);
        #1;
        model(n);
        chk({tag, " nbytes"}, obs_b.size(), exp_b.size());
        m = (obs_b.size() < exp_b.size()) ? obs_b.size() : exp_b.size();
        for (int i = 0; i < m; i++) chk({tag, " byte"}, {24'h0, obs_b[i]}, {24'h0, exp_b[i]});
        chk({tag, " nlast"}, obs_last.size(), (exp_done != 0 && exp_b.size() > 0) ? 1 : 0);
        if (obs_last.size() == 1 && exp_b.size() > 0)
            chk({tag, " lastpos"}, obs_last[0], exp_b.size() - 1);
        chk({tag, " done"}, obs_done, exp_done);
        chk({tag, " err"}, obs_err, exp_err);
        chk({tag, " both"}, obs_both, 0);
        chk({tag, " src"}, rx_ip_src, exp_src);
        chk({tag, " proto"}, {24'h0, rx_ip_protocol}, {24'h0, exp_proto});
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " src0"}, rx_ip_src, 32'h0);
        chk({tag, " proto0"}, {24'h0, rx_ip_protocol}, 32'h0);
        chk({tag, " pv0"}, {31'h0, rx_ip_payload_valid}, 32'h0);
        chk({tag, " pd0"}, {24'h0, rx_ip_payload}, 32'h0);
        chk({tag, " last0"}, {31'h0, rx_ip_last}, 32'h0);
        chk({tag, " done0"}, {31'h0, rx_ip_done}, 32'h0);
        chk({tag, " err0"}, {31'h0, rx_ip_err}, 32'h0);
    endtask

    initial begin
        int n;
        int sel;
        logic [31:0] dst;
        logic [15:0] fl;

        #1;
        chk_zero("reset");
        repeat (3) @(posedge RX_CLK);
        @(negedge RX_CLK);
        rst = 1'b1;

        lit_frame();
        run(frm.size(), "basic");
        chk("basic src lit", rx_ip_src, 32'hC0A8_0002);
        chk("basic proto lit", {24'h0, rx_ip_protocol}, 32'h11);

        lit_frame();
        frm[11] = 8'h7E;
        run(frm.size(), "badcsum");

        lit_frame();
        for (int i = 0; i < 18; i++) frm.push_back(8'($urandom));
        run(frm.size(), "padded");

        build(5, 8, 32'h0A00_0005, 32'hC0A8_0009, 8'h06, 16'h4000, 0, 1, 0);
        run(frm.size(), "otherdst");
        build(5, 8, 32'h0A00_0006, 32'hFFFF_FFFF, 8'h11, 16'h4000, 0, 1, 0);
        run(frm.size(), "bcast");

        build(6, 0, 32'h0A00_0007, 32'hC0A8_0001, 8'h01, 16'h0000, 0, 1, 0);
        run(frm.size(), "opt0len");

        lit_frame();
        run(22, "drop3");

        build(4, 4, 32'h0A00_0008, 32'hC0A8_0001, 8'h11, 16'h0000, 0, 1, 0);
        run(frm.size(), "ihl4");

        build(5, 6, 32'h0A00_0009, 32'hC0A8_0001, 8'h11, 16'h2000, 0, 1, 0);
        run(frm.size(), "mf");

        build(5, 6, 32'h0A00_000A, 32'hC0A8_0001, 8'h11, 16'h0010, 0, 1, 0);
        run(frm.size(), "fragoff");

        build(5, 0, 32'h0A00_000B, 32'hC0A8_0001, 8'h11, 16'h4000, 0, 1, 6);
        run(10, "drophdr");

        // Reset while the fourth payload byte is on the wire.
        lit_frame();
        clear_obs();
        for (int i = 0; i < 24; i++) begin
            @(posedge RX_CLK); #1;
            rx_payload_ipv4 = 1'b1;
            rx_payload      = frm[i];
        end
        #2;
        rst = 1'b0;
        #1;
        chk_zero("midrst");
        chk("midrst done", obs_done, 0);
        chk("midrst err", obs_err, 0);
        @(posedge RX_CLK); #1;
        rx_payload_ipv4 = 1'b0;
        rx_payload      = 8'h00;
        @(posedge RX_CLK); #1;
        rst = 1'b1;
        exp_src   = 32'h0;
        exp_proto = 8'h0;
        lit_frame();
        run(frm.size(), "afterrst");

        for (int k = 0; k < 40; k++) begin
            sel = $urandom_range(0, 9);
            dst = (sel < 5) ? ip_addr : (sel < 7) ? 32'hFFFF_FFFF : $urandom;
            fl  = ($urandom_range(0, 7) == 0) ? 16'h2000 :
                  ($urandom_range(0, 9) == 0) ? 16'h0003 : 16'h4000;
            build($urandom_range(5, 7), $urandom_range(0, 40), $urandom, dst, 8'($urandom), fl,
                  $urandom_range(0, 7) == 0, 1,
                  ($urandom_range(0, 1) != 0) ? $urandom_range(1, 20) : 0);
            n = frm.size();
            if ($urandom_range(0, 7) == 0) n = $urandom_range(1, frm.size() - 1);
            run(n, "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
